hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard and forwarding unit for the ID stage of the RISC-V core. It arbitrates rs1/rs2 operands across NUM_FWD in-flight pipeline stages, a long-latency unit (mul/div) writeback port, and the register file. A sequential scoreboard tracks outstanding long-latency destinations and generates RAW, WAW, data-not-ready and structural stalls. It also keeps a saturating stall-cycle counter and a sticky protocol-error flag.

## Interface
- XLEN, 32, data width
- RA_W, 5, register address width (2^RA_W architectural registers)
- NUM_FWD, 3, number of forwarding stages; index 0 is the youngest (EX)
- LU_DEPTH, 4, max outstanding long-latency ops (1..2^RA_W-1)
- CNT_W, 16, stall counter width
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- flush  in  1  kill the ID instruction this cycle; no scoreboard issue
- rs1_en, rs2_en  in  1 each  source operand used
- rs1_addr, rs2_addr  in  RA_W each  source register indexes
- rs1_data, rs2_data  in  XLEN each  register-file read values
- rd_en_id  in  1  ID instruction writes rd
- rd_addr_id  in  RA_W  ID destination
- id_long  in  1  ID instruction goes to the long-latency unit
- fwd_en  in  NUM_FWD  stage k writes a register
- fwd_rdy  in  NUM_FWD  stage k result is available (0 = load not yet returned, etc.)
- fwd_addr  in  NUM_FWD*RA_W  packed stage destinations, stage k at [k*RA_W +: RA_W]
- fwd_data  in  NUM_FWD*XLEN  packed stage results
- lu_done  in  1  long unit writes back this cycle
- lu_addr  in  RA_W  long unit destination
- lu_data  in  XLEN  long unit result
- cnt_clr  in  1  synchronous clear of stall_cnt
- stall_id  out  1  hold IF/ID, insert bubble into EX
- rs1_out, rs2_out  out  XLEN each  resolved operands
- sb_busy  out  1  at least one pending bit set
- sb_err  out  1  sticky protocol error
- stall_cnt  out  CNT_W  cycles with stall_id=1

## Operation
- State: pending[2^RA_W] bit vector, outstanding count oc (0..LU_DEPTH), stall_cnt, sb_err. All are reset to 0 by rst_n=0. The other outputs are combinational.
- Register x0 is never forwarded, never stalls and is never marked pending. Any rs addressed to x0 yields 0 when enabled.
- Operand resolution for rsN. Priority, first match wins:
  - rsN_en=0 gives 0.
  - addr=0 gives 0.
  - The lowest k with fwd_en[k] and fwd_addr[k]==addr gives fwd_data[k].
  - lu_done and lu_addr==addr gives lu_data.
  - Otherwise rsN_data.
- The effective pending bit for register r is pend_eff(r) = pending[r] & ~(lu_done & lu_addr==r).
- Stall causes, evaluated only when id_valid=1:
  - Not ready: the matching stage from the priority rule above has fwd_rdy[k]=0.
  - RAW long: an enabled rs with a nonzero address has pend_eff=1 and no fwd stage match.
  - WAW: rd_en_id and rd_addr_id!=0 and pend_eff(rd_addr_id).
  - Structural: id_long and oc_eff==LU_DEPTH, where oc_eff = oc - (lu_done accepted).
- stall_id is the OR of the four causes.
- Issue is id_valid & ~stall_id & ~flush & id_long & rd_en_id & rd_addr_id!=0. On issue, pending[rd] is set and oc is incremented.
- An accepted lu_done (pending[lu_addr]=1) clears pending[lu_addr] and decrements oc.
- Issue and completion in the same cycle:
  - oc is unchanged.
  - If both target the same register, the set wins and the bit stays 1.
- A lu_done with lu_addr=0 or pending[lu_addr]=0 is not accepted. In that case pending and oc are unchanged and sb_err is set; it stays 1 until reset.
- flush does not cancel pending bits; issued long ops always complete.
- stall_cnt increments when stall_id=1 and saturates at 2^CNT_W-1. cnt_clr has priority over the increment, so the counter goes to 0.
- sb_busy = |pending.

## Timing
- Operand outputs and stall_id are zero-latency combinational from the inputs and current state.
- pending, oc, stall_cnt and sb_err update on the rising edge of clk. An issue in cycle t is visible as a stall to a dependent instruction in ID at t+1.
- A consumer stalled on a pending register resolves in the cycle lu_done arrives. It takes lu_data in that cycle with no extra bubble.
- Reset asserted mid-operation clears all state immediately. Outstanding long ops completing after reset raise sb_err, and a bench must not do this.

## Test plan
- Reset, then rs1=x5 enabled, fwd_en=0, rs1_data=0x11 -> rs1_out=0x11, stall_id=0, stall_cnt=0, sb_busy=0.
- Stage 0 and stage 2 both write x7 (0xA, 0xC), rs2=x7 -> rs2_out=0xA. Then set fwd_rdy[0]=0 -> stall_id=1 and stall_cnt increments every cycle.
- Issue long op to x9 at t. At t+1, rs1=x9 -> stall_id=1 for three cycles. At t+4 lu_done with x9 and data 0x55 -> rs1_out=0x55, stall_id=0, sb_busy=0 at t+5.
- With LU_DEPTH=4, issue long ops to x1..x4 -> oc=4 and a 5th id_long stalls. The same cycle plus lu_done x1 -> no stall, oc stays 4.
- x3 pending and ID writes x3 (rd_en_id, non-long) -> WAW stall until lu_done x3. A rs addressed to x0 with fwd stage writing x0 with 0xFF -> 0.
- lu_done x12 while not pending -> sb_err=1 and oc unchanged. stall_cnt preset near max saturates at 0xFFFF. cnt_clr together with a stall -> 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bundle: ID-stage operands and destination, forwarding stages, long-unit
// writeback, and the resolved operand / stall outputs.
//   master: ID-stage control (drives requests, observes resolved operands and stall status)
//   slave : hazard_scoreboard (consumes requests, produces operands and stall status)
interface hazard_scoreboard_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 16
) ();
  logic                    id_valid;
  logic                    flush;
  logic                    rs1_en;
  logic                    rs2_en;
  logic [RA_W-1:0]         rs1_addr;
  logic [RA_W-1:0]         rs2_addr;
  logic [XLEN-1:0]         rs1_data;
  logic [XLEN-1:0]         rs2_data;
  logic                    rd_en_id;
  logic [RA_W-1:0]         rd_addr_id;
  logic                    id_long;
  logic [NUM_FWD-1:0]      fwd_en;
  logic [NUM_FWD-1:0]      fwd_rdy;
  logic [NUM_FWD*RA_W-1:0] fwd_addr;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    lu_done;
  logic [RA_W-1:0]         lu_addr;
  logic [XLEN-1:0]         lu_data;
  logic                    cnt_clr;
  logic                    stall_id;
  logic [XLEN-1:0]         rs1_out;
  logic [XLEN-1:0]         rs2_out;
  logic                    sb_busy;
  logic                    sb_err;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output id_valid, flush, rs1_en, rs2_en, rs1_addr, rs2_addr, rs1_data, rs2_data,
           rd_en_id, rd_addr_id, id_long, fwd_en, fwd_rdy, fwd_addr, fwd_data,
           lu_done, lu_addr, lu_data, cnt_clr,
    input  stall_id, rs1_out, rs2_out, sb_busy, sb_err, stall_cnt
  );

  modport slave (
    input  id_valid, flush, rs1_en, rs2_en, rs1_addr, rs2_addr, rs1_data, rs2_data,
           rd_en_id, rd_addr_id, id_long, fwd_en, fwd_rdy, fwd_addr, fwd_data,
           lu_done, lu_addr, lu_data, cnt_clr,
    output stall_id, rs1_out, rs2_out, sb_busy, sb_err, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard and forwarding unit.
// Resolves rs1/rs2 from forwarding stages (youngest first), the long-unit writeback port, or
// the register file; tracks outstanding long-latency destinations in a pending bit vector and
// raises stall_id on not-ready forwards, RAW/WAW against pending registers, and a full long unit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sb         : hazard_scoreboard_if.slave bundle (requests in, operands/stall/status out)
module hazard_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned NUM_FWD  = 3,
  parameter int unsigned LU_DEPTH = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_scoreboard_if.slave sb
);

  localparam int unsigned NREG = 1 << RA_W;
  localparam int unsigned OC_W = $clog2(LU_DEPTH + 1);

  logic [NREG-1:0]  pending_q, pending_d;
  logic [NREG-1:0]  lu_hit, pend_eff;
  logic [OC_W-1:0]  oc_q, oc_d, oc_eff;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             lu_acc;
  logic             cause_nrdy, cause_raw, cause_waw, cause_struct;
  logic             stall, issue;

  logic [1:0]                 rs_en;
  logic [1:0][RA_W-1:0]       rs_addr;
  logic [1:0][XLEN-1:0]       rs_rf;
  logic [1:0][XLEN-1:0]       rs_res;
  logic [1:0]                 rs_hit;
  logic [1:0]                 rs_rdy;
  logic [1:0]                 rs_raw;

  assign rs_en   = {sb.rs2_en, sb.rs1_en};
  assign rs_addr = {sb.rs2_addr, sb.rs1_addr};
  assign rs_rf   = {sb.rs2_data, sb.rs1_data};

  // A writeback landing this cycle hides the pending bit so the consumer proceeds with lu_data.
  assign lu_hit   = sb.lu_done ? (NREG'(1) << sb.lu_addr) : '0;
  assign pend_eff = pending_q & ~lu_hit;
  assign lu_acc   = sb.lu_done & (sb.lu_addr != '0) & pending_q[sb.lu_addr];

  for (genvar gi = 0; gi < 2; gi++) begin : g_rs
    logic [XLEN-1:0] res;
    logic            hit;
    logic            rdy;

    always_comb begin
      res = rs_rf[gi];
      hit = 1'b0;
      rdy = 1'b1;
      // Walk oldest to youngest so the lowest matching stage is the last assignment.
      for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
        if (sb.fwd_en[k] && (sb.fwd_addr[k*RA_W +: RA_W] == rs_addr[gi])) begin
          hit = 1'b1;
          rdy = sb.fwd_rdy[k];
          res = sb.fwd_data[k*XLEN +: XLEN];
        end
      end
      if (!hit && sb.lu_done && (sb.lu_addr == rs_addr[gi])) begin
        res = sb.lu_data;
      end
      if (!rs_en[gi] || (rs_addr[gi] == '0)) begin
        res = '0;
        hit = 1'b0;
        rdy = 1'b1;
      end
    end

    assign rs_res[gi] = res;
    assign rs_hit[gi] = hit;
    assign rs_rdy[gi] = rdy;
    assign rs_raw[gi] = rs_en[gi] & (rs_addr[gi] != '0) & pend_eff[rs_addr[gi]] & ~hit;
  end

  assign oc_eff       = oc_q - OC_W'(lu_acc);
  assign cause_nrdy   = |(rs_hit & ~rs_rdy);
  assign cause_raw    = |rs_raw;
  assign cause_waw    = sb.rd_en_id & (sb.rd_addr_id != '0) & pend_eff[sb.rd_addr_id];
  assign cause_struct = sb.id_long & (oc_eff == OC_W'(LU_DEPTH));
  assign stall        = sb.id_valid & (cause_nrdy | cause_raw | cause_waw | cause_struct);

  assign issue = sb.id_valid & ~stall & ~sb.flush & sb.id_long & sb.rd_en_id &
                 (sb.rd_addr_id != '0);

  always_comb begin
    pending_d = pending_q;
    if (lu_acc) begin
      pending_d[sb.lu_addr] = 1'b0;
    end
    // Set after clear: same-register issue and completion leaves the bit set.
    if (issue) begin
      pending_d[sb.rd_addr_id] = 1'b1;
    end
  end

  assign oc_d  = oc_q + OC_W'(issue) - OC_W'(lu_acc);
  assign err_d = err_q | (sb.lu_done & ~lu_acc);

  always_comb begin
    cnt_d = cnt_q;
    if (sb.cnt_clr) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      oc_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      oc_q      <= oc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign sb.stall_id  = stall;
  assign sb.rs1_out   = rs_res[0];
  assign sb.rs2_out   = rs_res[1];
  assign sb.sb_busy   = |pending_q;
  assign sb.sb_err    = err_q;
  assign sb.stall_cnt = cnt_q;

endmodule
